// File: rtl/silife_pkg.sv
// Shared constants and enums for the SiLife grid sequencer.
package silife_pkg;

   localparam int unsigned GRID_ROWS    = 8;
   localparam int unsigned GRID_WIDTH   = 8;
   localparam int unsigned GRID_POP_W   = $clog2(GRID_ROWS * GRID_WIDTH + 1);
   localparam int unsigned DEF_PERIOD_W = 16;
   localparam int unsigned GEN_W        = 16;
   localparam int unsigned CMD_GENS_W   = 8;

   typedef enum logic [1:0] {
      OP_LOAD = 2'd0,
      OP_RUN  = 2'd1,
      OP_STOP = 2'd2,
      OP_STEP = 2'd3
   } cmd_op_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_WAIT = 3'd2,
      ST_STEP = 3'd3,
      ST_SCAN = 3'd4
   } state_e;

endpackage

// File: rtl/silife_row_scanner.sv
// Row-by-row grid readback: popcount, snapshot compare/replace and scan results.
module silife_row_scanner
   import silife_pkg::*;
#(
   parameter int unsigned ROWS    = GRID_ROWS,
   parameter int unsigned WIDTH   = GRID_WIDTH,
   localparam int unsigned ROW_W  = $clog2(ROWS),
   localparam int unsigned POP_W  = $clog2(ROWS * WIDTH + 1)
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             scan_i,
   input  logic [ROW_W-1:0] row_i,
   input  logic [WIDTH-1:0] cells_i,
   output logic [POP_W-1:0] population_o,
   output logic             stable_o,
   output logic             extinct_o,
   output logic             stable_next_c,
   output logic             extinct_next_c
);

   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

   logic [WIDTH-1:0] snap_q [ROWS];
   logic [POP_W-1:0] acc_q, acc_d;
   logic [POP_W-1:0] row_pop;
   logic             eq_q, eq_d;
   logic [POP_W-1:0] pop_q;
   logic             stable_q, extinct_q;
   logic             first_row, last_row;

   assign first_row = (row_i == '0);
   assign last_row  = (row_i == ROW_LAST);

   // Live-cell count of the row currently presented by the grid.
   always_comb begin
      row_pop = '0;
      for (int i = 0; i < WIDTH; i++) begin
         row_pop = row_pop + POP_W'(cells_i[i]);
      end
   end

   // Running population and all-rows-equal flag; both restart on row 0.
   always_comb begin
      acc_d = acc_q;
      eq_d  = eq_q;
      if (scan_i) begin
         acc_d = (first_row ? '0 : acc_q) + row_pop;
         eq_d  = (first_row ? 1'b1 : eq_q) && (cells_i == snap_q[row_i]);
      end
   end

   // Results as they will be once the final row is folded in.
   assign stable_next_c  = eq_d;
   assign extinct_next_c = (acc_d == '0);

   // Accumulators, snapshot RAM and result registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < ROWS; r++) begin
            snap_q[r] <= '0;
         end
         acc_q     <= '0;
         eq_q      <= 1'b0;
         pop_q     <= '0;
         stable_q  <= 1'b0;
         extinct_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         eq_q  <= eq_d;
         if (scan_i) begin
            snap_q[row_i] <= cells_i;
            if (last_row) begin
               pop_q     <= acc_d;
               stable_q  <= eq_d;
               extinct_q <= (acc_d == '0);
            end
         end
      end
   end

   assign population_o = pop_q;
   assign stable_o     = stable_q;
   assign extinct_o    = extinct_q;

endmodule

// File: rtl/silife_sequencer.sv
// SiLife grid controller: pattern load, timed generation stepping and readback scan.
module silife_sequencer
   import silife_pkg::*;
#(
   parameter int unsigned ROWS     = GRID_ROWS,
   parameter int unsigned WIDTH    = GRID_WIDTH,
   parameter int unsigned PERIOD_W = DEF_PERIOD_W,
   localparam int unsigned ROW_W   = $clog2(ROWS),
   localparam int unsigned POP_W   = $clog2(ROWS * WIDTH + 1)
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [CMD_GENS_W-1:0] cmd_gens,
   input  logic                  cmd_auto_halt,
   input  logic [PERIOD_W-1:0]   period,
   input  logic                  row_valid,
   output logic                  row_ready,
   input  logic [WIDTH-1:0]      row_data,
   output logic [ROW_W-1:0]      grid_row_select,
   output logic [WIDTH-1:0]      grid_set_cells,
   output logic [WIDTH-1:0]      grid_clear_cells,
   output logic                  grid_enable,
   input  logic [WIDTH-1:0]      grid_cells,
   output logic                  busy,
   output logic [GEN_W-1:0]      gen_count,
   output logic [POP_W-1:0]      population,
   output logic                  stable,
   output logic                  extinct,
   output logic                  done
);

   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

   state_e                state_q, state_d;
   logic [ROW_W-1:0]      row_idx_q, row_idx_d;
   logic [PERIOD_W-1:0]   per_cnt_q, per_cnt_d;
   logic [PERIOD_W-1:0]   per_lat_q, per_lat_d;
   logic [CMD_GENS_W-1:0] gens_rem_q, gens_rem_d;
   logic                  bounded_q, bounded_d;
   logic                  auto_halt_q, auto_halt_d;
   logic                  oneshot_q, oneshot_d;
   logic                  stop_pend_q, stop_pend_d;
   logic [GEN_W-1:0]      gen_cnt_q, gen_cnt_d;
   logic                  done_q, done_d;

   logic                  stop_req;
   logic                  scan_strobe;
   logic                  stable_next_c, extinct_next_c;

   // STOP bypasses cmd_ready while running; LOAD must always complete.
   assign stop_req = cmd_valid && (cmd_op_e'(cmd_op) == OP_STOP) &&
                     ((state_q == ST_WAIT) || (state_q == ST_STEP) || (state_q == ST_SCAN));

   // Next-state, grid drive and bookkeeping.
   always_comb begin
      state_d          = state_q;
      row_idx_d        = row_idx_q;
      per_cnt_d        = per_cnt_q;
      per_lat_d        = per_lat_q;
      gens_rem_d       = gens_rem_q;
      bounded_d        = bounded_q;
      auto_halt_d      = auto_halt_q;
      oneshot_d        = oneshot_q;
      stop_pend_d      = stop_pend_q;
      gen_cnt_d        = gen_cnt_q;
      done_d           = 1'b0;
      grid_row_select  = '0;
      grid_set_cells   = '0;
      grid_clear_cells = '0;
      grid_enable      = 1'b0;
      scan_strobe      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            per_cnt_d = '0;
            if (cmd_valid) begin
               case (cmd_op_e'(cmd_op))
                  OP_LOAD: begin
                     state_d   = ST_LOAD;
                     row_idx_d = '0;
                     gen_cnt_d = '0;
                     oneshot_d = 1'b1;
                  end
                  OP_RUN: begin
                     state_d     = ST_WAIT;
                     gens_rem_d  = cmd_gens;
                     bounded_d   = (cmd_gens != '0);
                     auto_halt_d = cmd_auto_halt;
                     per_lat_d   = (period == '0) ? PERIOD_W'(1) : period;
                     oneshot_d   = 1'b0;
                  end
                  OP_STEP: begin
                     state_d   = ST_STEP;
                     bounded_d = 1'b0;
                     oneshot_d = 1'b1;
                  end
                  default: done_d = 1'b1;
               endcase
            end
         end

         ST_LOAD: begin
            grid_row_select = row_idx_q;
            if (row_valid) begin
               grid_set_cells   = row_data;
               grid_clear_cells = ~row_data;
               row_idx_d        = row_idx_q + ROW_W'(1);
               if (row_idx_q == ROW_LAST) begin
                  state_d   = ST_SCAN;
                  row_idx_d = '0;
               end
            end
         end

         ST_WAIT: begin
            if (stop_pend_q || stop_req) begin
               state_d = ST_IDLE;
            end else if (per_cnt_q == per_lat_q - PERIOD_W'(1)) begin
               state_d   = ST_STEP;
               per_cnt_d = '0;
            end else begin
               per_cnt_d = per_cnt_q + PERIOD_W'(1);
            end
         end

         ST_STEP: begin
            grid_enable = 1'b1;
            gen_cnt_d   = gen_cnt_q + GEN_W'(1);
            if (bounded_q) begin
               gens_rem_d = gens_rem_q - CMD_GENS_W'(1);
            end
            if (stop_req) begin
               stop_pend_d = 1'b1;
            end
            state_d   = ST_SCAN;
            row_idx_d = '0;
         end

         ST_SCAN: begin
            grid_row_select = row_idx_q;
            scan_strobe     = 1'b1;
            if (stop_req) begin
               stop_pend_d = 1'b1;
            end
            if (row_idx_q == ROW_LAST) begin
               row_idx_d = '0;
               if (stop_pend_q || stop_req || oneshot_q) begin
                  state_d = ST_IDLE;
               end else if (bounded_q && (gens_rem_q == '0)) begin
                  state_d = ST_IDLE;
               end else if (auto_halt_q && (stable_next_c || extinct_next_c)) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_WAIT;
               end
            end else begin
               row_idx_d = row_idx_q + ROW_W'(1);
            end
         end

         default: state_d = ST_IDLE;
      endcase

      // Every return to IDLE pulses done and drops any pending STOP.
      if ((state_d == ST_IDLE) && (state_q != ST_IDLE)) begin
         done_d      = 1'b1;
         stop_pend_d = 1'b0;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         row_idx_q   <= '0;
         per_cnt_q   <= '0;
         per_lat_q   <= '0;
         gens_rem_q  <= '0;
         bounded_q   <= 1'b0;
         auto_halt_q <= 1'b0;
         oneshot_q   <= 1'b0;
         stop_pend_q <= 1'b0;
         gen_cnt_q   <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_idx_q   <= row_idx_d;
         per_cnt_q   <= per_cnt_d;
         per_lat_q   <= per_lat_d;
         gens_rem_q  <= gens_rem_d;
         bounded_q   <= bounded_d;
         auto_halt_q <= auto_halt_d;
         oneshot_q   <= oneshot_d;
         stop_pend_q <= stop_pend_d;
         gen_cnt_q   <= gen_cnt_d;
         done_q      <= done_d;
      end
   end

   silife_row_scanner #(
      .ROWS  (ROWS),
      .WIDTH (WIDTH)
   ) u_scanner (
      .clk            (clk),
      .reset          (reset),
      .scan_i         (scan_strobe),
      .row_i          (row_idx_q),
      .cells_i        (grid_cells),
      .population_o   (population),
      .stable_o       (stable),
      .extinct_o      (extinct),
      .stable_next_c  (stable_next_c),
      .extinct_next_c (extinct_next_c)
   );

   assign cmd_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign row_ready = (state_q == ST_LOAD);
   assign gen_count = gen_cnt_q;
   assign done      = done_q;

endmodule

// File: tb/tb_silife_sequencer.sv
// Bench for silife_sequencer: behavioural 8x8 grid, reference life model and done-driven scoreboard.
module tb_silife_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'd0;
   logic [7:0]  cmd_gens = 8'd0;
   logic        cmd_auto_halt = 1'b0;
   logic [15:0] period = 16'd1;
   logic        row_valid = 1'b0;
   logic        row_ready;
   logic [7:0]  row_data = 8'd0;
   logic [2:0]  grid_row_select;
   logic [7:0]  grid_set_cells;
   logic [7:0]  grid_clear_cells;
   logic        grid_enable;
   logic [7:0]  grid_cells;
   logic        busy;
   logic [15:0] gen_count;
   logic [6:0]  population;
   logic        stable;
   logic        extinct;
   logic        done;

   silife_sequencer dut (
      .clk              (clk),
      .reset            (reset),
      .cmd_valid        (cmd_valid),
      .cmd_ready        (cmd_ready),
      .cmd_op           (cmd_op),
      .cmd_gens         (cmd_gens),
      .cmd_auto_halt    (cmd_auto_halt),
      .period           (period),
      .row_valid        (row_valid),
      .row_ready        (row_ready),
      .row_data         (row_data),
      .grid_row_select  (grid_row_select),
      .grid_set_cells   (grid_set_cells),
      .grid_clear_cells (grid_clear_cells),
      .grid_enable      (grid_enable),
      .grid_cells       (grid_cells),
      .busy             (busy),
      .gen_count        (gen_count),
      .population       (population),
      .stable           (stable),
      .extinct          (extinct),
      .done             (done)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Game of Life step on an 8x8 grid with dead borders; row r occupies bits [r*8 +: 8].
   function automatic logic [63:0] life64(input logic [63:0] g);
      logic [63:0] nx;
      int n;
      nx = '0;
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            n = 0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  if ((dr != 0 || dc != 0) && (r + dr >= 0) && (r + dr < 8) &&
                      (c + dc >= 0) && (c + dc < 8)) begin
                     n += int'(g[(r + dr) * 8 + c + dc]);
                  end
               end
            end
            nx[r * 8 + c] = g[r * 8 + c] ? (n == 2 || n == 3) : (n == 3);
         end
      end
      return nx;
   endfunction

   // Grid the DUT drives: writes and generation steps land on the clock edge.
   logic [63:0] env_g = '0;
   assign grid_cells = env_g[int'(grid_row_select) * 8 +: 8];

   always @(posedge clk) begin
      if (grid_enable) begin
         env_g <= life64(env_g);
      end else if ((grid_set_cells | grid_clear_cells) != 8'd0) begin
         env_g[int'(grid_row_select) * 8 +: 8] <=
            (env_g[int'(grid_row_select) * 8 +: 8] | grid_set_cells) & ~grid_clear_cells;
      end
   end

   typedef struct {
      string       tag;
      logic [15:0] gen;
      logic [6:0]  pop;
      logic        chk_st;
      logic        st;
      logic        ext;
   } exp_t;

   exp_t        sb[$];
   logic [63:0] ref_g   = '0;
   logic [15:0] ref_gen = '0;

   task automatic push_exp(input string tag, input logic chk_st, input logic st);
      exp_t e;
      e.tag    = tag;
      e.gen    = ref_gen;
      e.pop    = 7'($countones(ref_g));
      e.chk_st = chk_st;
      e.st     = st;
      e.ext    = (ref_g == '0);
      sb.push_back(e);
   endtask

   // Monitors: cycle count, enable pulses and spacing, done-driven scoreboard compare.
   int cyc = 0;
   int en_cnt = 0;
   int done_cnt = 0;
   int last_en_cyc = -1;
   int last_gap = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (grid_enable) begin
         en_cnt++;
         if (last_en_cyc >= 0) last_gap = cyc - last_en_cyc;
         last_en_cyc = cyc;
         check("enable_no_write", 32'(grid_set_cells | grid_clear_cells), 32'd0);
      end
      if (done) begin
         done_cnt++;
         if (sb.size() == 0) begin
            check("done_unexpected", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, "_gen"}, 32'(gen_count), 32'(e.gen));
            check({e.tag, "_pop"}, 32'(population), 32'(e.pop));
            check({e.tag, "_extinct"}, 32'(extinct), 32'(e.ext));
            if (e.chk_st) check({e.tag, "_stable"}, 32'(stable), 32'(e.st));
         end
      end
   end

   task automatic send_cmd(input logic [1:0] op, input logic [7:0] gens, input logic ah);
      int n;
      n = 0;
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_gens = gens;
      cmd_auto_halt = ah;
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) check("cmd_ready_timeout", 32'd0, 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic feed_rows(input logic [63:0] pat, input int nrows);
      int n;
      for (int r = 0; r < nrows; r++) begin
         row_valid = 1'b1;
         row_data = pat[r * 8 +: 8];
         n = 0;
         while (!row_ready && n < 50) begin
            @(negedge clk);
            n++;
         end
         if (!row_ready) check("row_ready_timeout", 32'd0, 32'd1);
         @(negedge clk);
      end
      row_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int start;
      int n;
      start = done_cnt;
      n = 0;
      while (done_cnt == start && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (done_cnt == start) check({tag, "_done_timeout"}, 32'd0, 32'd1);
      @(negedge clk);
   endtask

   task automatic load(input string tag, input logic [63:0] pat);
      ref_g = pat;
      ref_gen = '0;
      push_exp(tag, 1'b0, 1'b0);
      send_cmd(2'd0, 8'd0, 1'b0);
      feed_rows(pat, 8);
      wait_done(tag, 40);
   endtask

   localparam logic [63:0] BLINKER = 64'h0000_0010_1010_0000;
   localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;
   localparam logic [63:0] SINGLE  = 64'h0000_0000_0000_0001;
   localparam logic [63:0] JUNK    = 64'h0000_0000_00FF_FFFF;
   localparam logic [63:0] HBLINK  = 64'h0000_0000_3800_0000;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      int en0, d0;
      logic [63:0] prev;
      logic [7:0] row3;

      repeat (3) @(negedge clk);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_row_ready", 32'(row_ready), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_enable", 32'(grid_enable), 32'd0);
      check("rst_outputs", {gen_count, 9'(population), stable, extinct, grid_set_cells[3:0]}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Blinker load
      load("load_blinker", BLINKER);
      row3 = env_g[31:24];
      check("load_row3", 32'(row3), 32'h10);

      // Two bounded generations at period 1
      period = 16'd1;
      en0 = en_cnt;
      prev = life64(ref_g);
      ref_g = life64(prev);
      ref_gen = 16'd2;
      push_exp("run2", 1'b1, ref_g == prev);
      send_cmd(2'd1, 8'd2, 1'b0);
      wait_done("run2", 100);
      check("run2_enables", 32'(en_cnt - en0), 32'd2);
      check("run2_spacing", 32'(last_gap), 32'd10);

      // Block with auto-halt, unbounded
      load("load_block", BLOCK);
      for (int i = 0; i < 100; i++) begin
         prev = ref_g;
         ref_g = life64(ref_g);
         ref_gen++;
         if (ref_g == prev || ref_g == '0) break;
      end
      push_exp("block_halt", 1'b1, ref_g == prev);
      send_cmd(2'd1, 8'd0, 1'b1);
      wait_done("block_halt", 500);

      // Single cell, one STEP
      load("load_single", SINGLE);
      en0 = en_cnt;
      prev = ref_g;
      ref_g = life64(ref_g);
      ref_gen++;
      push_exp("step", 1'b1, ref_g == prev);
      send_cmd(2'd3, 8'd0, 1'b0);
      wait_done("step", 40);
      check("step_enables", 32'(en_cnt - en0), 32'd1);

      // STOP while waiting out a long period
      period = 16'd100;
      en0 = en_cnt;
      d0 = done_cnt;
      push_exp("stop", 1'b0, 1'b0);
      send_cmd(2'd1, 8'd0, 1'b0);
      repeat (20) @(negedge clk);
      check("stop_busy_before", 32'(busy), 32'd1);
      cmd_valid = 1'b1;
      cmd_op = 2'd2;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("stop_busy_after", 32'(busy), 32'd0);
      repeat (150) @(negedge clk);
      check("stop_enables", 32'(en_cnt - en0), 32'd0);
      check("stop_done_once", 32'(done_cnt - d0), 32'd1);

      // Reset in the middle of a load, then a clean reload from row 0
      load("load_block2", BLOCK);
      send_cmd(2'd0, 8'd0, 1'b0);
      feed_rows(JUNK, 3);
      reset = 1'b1;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_row_ready", 32'(row_ready), 32'd0);
      check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("mid_rst_counters", {gen_count, 9'(population), 7'd0}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      load("reload", HBLINK);
      check("reload_grid_lo", env_g[31:0], HBLINK[31:0]);
      check("reload_grid_hi", env_g[63:32], HBLINK[63:32]);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
